// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA box renderer slice.
// Holds the default raster size, the RGB444 pixel type, the fixed
// colours and the encoding of the four diagonal motion directions.
package vga_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t COLOR_BLACK = 12'h000;
  localparam rgb12_t COLOR_WHITE = 12'hFFF;

  // Encoded as {y_neg, x_neg}. A set bit means that axis is moving
  // towards zero, so each axis can flip its own bit independently.
  typedef enum logic [1:0] {
    SE = 2'b00,
    SW = 2'b01,
    NE = 2'b10,
    NW = 2'b11
  } dir_t;

endpackage

// File: rtl/vga_box_renderer_if.sv
// Raster bus between the sync generator and the box renderer.
// master: the side that produces counters/raw sync and consumes pixels.
// slave:  the renderer, which consumes counters and produces pixels.
interface vga_box_renderer_if;

  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync_in;
  logic       vsync_in;
  logic       hsync;
  logic       vsync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  modport master (
    output hpos, vpos, hsync_in, vsync_in,
    input  hsync, vsync, red, green, blue
  );

  modport slave (
    input  hpos, vpos, hsync_in, vsync_in,
    output hsync, vsync, red, green, blue
  );

endinterface

// File: rtl/vga_box_renderer_box_motion.sv
// Bouncing-box motion: holds the box top-left corner and the diagonal
// direction. Position only moves on the per-frame tick, and each axis
// reflects off its own wall, so a corner hit flips both axes at once.
module box_motion
  import vga_pkg::*;
#(
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int BOX_SIZE = 32,
  parameter int SPEED    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam logic [9:0] X_MAX = 10'(H_RES - BOX_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_RES - BOX_SIZE);
  localparam logic [9:0] X_CTR = 10'((H_RES - BOX_SIZE) / 2);
  localparam logic [9:0] Y_CTR = 10'((V_RES - BOX_SIZE) / 2);
  localparam logic [10:0] SPD  = 11'(SPEED);

  dir_t       state;
  dir_t       state_nxt;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic [10:0] x_step;
  logic [10:0] y_step;

  // One axis step, returned as {neg_next, pos_next}. Sums are done in
  // 11 bits so pos + SPEED can never wrap before the wall compare.
  function automatic logic [10:0] axis_step(input logic [9:0] pos,
                                            input logic       neg,
                                            input logic [9:0] lim);
    logic [10:0] p;
    logic [10:0] l;
    logic [10:0] r;
    p = {1'b0, pos};
    l = {1'b0, lim};
    if (!neg) begin
      if (p + SPD >= l) r = {1'b1, lim};
      else              r = {1'b0, 10'(p + SPD)};
    end else begin
      if (p <= SPD) r = {1'b0, 10'd0};
      else          r = {1'b1, 10'(p - SPD)};
    end
    return r;
  endfunction

  // Direction and position registers; reset recentres the box heading SE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SE;
      x_q   <= X_CTR;
      y_q   <= Y_CTR;
    end else begin
      state <= state_nxt;
      x_q   <= x_nxt;
      y_q   <= y_nxt;
    end
  end

  // Next direction/position: hold between ticks, step both axes on a tick.
  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    x_step    = axis_step(x_q, state[0], X_MAX);
    y_step    = axis_step(y_q, state[1], Y_MAX);
    if (tick) begin
      x_nxt     = x_step[9:0];
      y_nxt     = y_step[9:0];
      state_nxt = dir_t'({y_step[10], x_step[10]});
    end
  end

  assign box_x = x_q;
  assign box_y = y_q;

endmodule

// File: rtl/vga_box_renderer.sv
// Pixel stage behind the VGA sync generator: draws a solid bouncing
// square over a flat background with a fixed 2-cycle latency, and
// delays hsync/vsync by the same amount so they stay aligned with RGB.
// Optional feature: define VGA_BOX_BORDER_EN to paint a one-pixel white
// frame around the active area (border wins over box and background).
module vga_box_renderer
  import vga_pkg::*;
#(
  parameter int     H_RES     = H_RES_DEF,
  parameter int     V_RES     = V_RES_DEF,
  parameter int     BOX_SIZE  = 32,
  parameter int     SPEED     = 2,
  parameter rgb12_t BOX_COLOR = 12'hF80,
  parameter rgb12_t BG_COLOR  = 12'h008
) (
  input logic               clk,
  input logic               rst_n,
  vga_box_renderer_if.slave vga
);

  logic        tick;
  logic [9:0]  box_x;
  logic [9:0]  box_y;
  logic [10:0] h_w;
  logic [10:0] v_w;
  logic [10:0] bx_w;
  logic [10:0] by_w;
  logic        active_w;
  logic        in_box_w;

  logic        active_p1;
  logic        in_box_p1;
  logic        hsync_p1;
  logic        vsync_p1;

  rgb12_t      rgb_p2;
  logic        hsync_p2;
  logic        vsync_p2;

`ifdef VGA_BOX_BORDER_EN
  logic        border_w;
  logic        border_p1;

  function automatic rgb12_t pixel_color(input logic act,
                                         input logic border,
                                         input logic box);
    rgb12_t c;
    if (!act)        c = COLOR_BLACK;
    else if (border) c = COLOR_WHITE;
    else if (box)    c = BOX_COLOR;
    else             c = BG_COLOR;
    return c;
  endfunction
`else
  function automatic rgb12_t pixel_color(input logic act,
                                         input logic box);
    rgb12_t c;
    if (!act)     c = COLOR_BLACK;
    else if (box) c = BOX_COLOR;
    else          c = BG_COLOR;
    return c;
  endfunction
`endif

  // First blanking line, first pixel: a once-per-frame strobe inside vblank,
  // so the box never moves while visible lines are being drawn.
  assign tick = (vga.vpos == 10'(V_RES)) && (vga.hpos == 10'd0);

  box_motion #(
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .BOX_SIZE(BOX_SIZE),
    .SPEED   (SPEED)
  ) u_motion (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .box_x(box_x),
    .box_y(box_y)
  );

  assign h_w  = {1'b0, vga.hpos};
  assign v_w  = {1'b0, vga.vpos};
  assign bx_w = {1'b0, box_x};
  assign by_w = {1'b0, box_y};

  assign active_w = (h_w < 11'(H_RES)) && (v_w < 11'(V_RES));
  assign in_box_w = (h_w >= bx_w) && (h_w < bx_w + 11'(BOX_SIZE)) &&
                    (v_w >= by_w) && (v_w < by_w + 11'(BOX_SIZE));

`ifdef VGA_BOX_BORDER_EN
  assign border_w = (h_w == 11'd0) || (h_w == 11'(H_RES - 1)) ||
                    (v_w == 11'd0) || (v_w == 11'(V_RES - 1));
`endif

  // ---- stage 1: region classification and raw sync capture ----
  // Register the active/box decisions alongside the sync inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_p1 <= 1'b0;
      in_box_p1 <= 1'b0;
      hsync_p1  <= 1'b1;
      vsync_p1  <= 1'b1;
`ifdef VGA_BOX_BORDER_EN
      border_p1 <= 1'b0;
`endif
    end else begin
      active_p1 <= active_w;
      in_box_p1 <= in_box_w;
      hsync_p1  <= vga.hsync_in;
      vsync_p1  <= vga.vsync_in;
`ifdef VGA_BOX_BORDER_EN
      border_p1 <= border_w;
`endif
    end
  end

  // ---- stage 2: colour resolve and aligned sync output ----
  // Turn the stage-1 flags into the final colour; blanking forces black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2   <= COLOR_BLACK;
      hsync_p2 <= 1'b1;
      vsync_p2 <= 1'b1;
    end else begin
`ifdef VGA_BOX_BORDER_EN
      rgb_p2   <= pixel_color(active_p1, border_p1, in_box_p1);
`else
      rgb_p2   <= pixel_color(active_p1, in_box_p1);
`endif
      hsync_p2 <= hsync_p1;
      vsync_p2 <= vsync_p1;
    end
  end

  assign vga.red   = rgb_p2[11:8];
  assign vga.green = rgb_p2[7:4];
  assign vga.blue  = rgb_p2[3:0];
  assign vga.hsync = hsync_p2;
  assign vga.vsync = vsync_p2;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Scoreboard bench for vga_box_renderer. dut_a uses the full 640x480
// raster; dut_b uses a 96x96 raster so the box reaches a corner quickly.
module tb_vga_box_renderer;
  import vga_pkg::*;

  localparam logic [11:0] BOX = 12'hF80;
  localparam logic [11:0] BG  = 12'h008;
  localparam logic [11:0] BLK = 12'h000;
`ifdef VGA_BOX_BORDER_EN
  localparam logic [11:0] EDGE_EXP = 12'hFFF;
`else
  localparam logic [11:0] EDGE_EXP = 12'h008;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  // Scoreboard: expected {hsync, vsync, rgb} plus due cycle and target DUT.
  int          q_due[$];
  bit          q_sel[$];
  logic [13:0] q_exp[$];
  string       q_nm[$];

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_box_renderer_if bus_a ();
  vga_box_renderer_if bus_b ();

  vga_box_renderer #(
    .H_RES(640), .V_RES(480), .BOX_SIZE(32), .SPEED(2),
    .BOX_COLOR(12'hF80), .BG_COLOR(12'h008)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .vga(bus_a)
  );

  vga_box_renderer #(
    .H_RES(96), .V_RES(96), .BOX_SIZE(32), .SPEED(2),
    .BOX_COLOR(12'hF80), .BG_COLOR(12'h008)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .vga(bus_b)
  );

  task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got hs=%b vs=%b rgb=%h, want hs=%b vs=%b rgb=%h",
               nm, act[13], act[12], act[11:0], exp[13], exp[12], exp[11:0]);
    end
  endtask

  // Monitor: compare each scoreboard entry when its output cycle arrives.
  always @(negedge clk) begin
    logic [13:0] act;
    while (q_due.size() > 0 && q_due[0] == cyc) begin
      if (q_sel[0])
        act = {bus_b.hsync, bus_b.vsync, bus_b.red, bus_b.green, bus_b.blue};
      else
        act = {bus_a.hsync, bus_a.vsync, bus_a.red, bus_a.green, bus_a.blue};
      check(q_nm[0], act, q_exp[0]);
      void'(q_due.pop_front());
      void'(q_sel.pop_front());
      void'(q_exp.pop_front());
      void'(q_nm.pop_front());
    end
  end

  task automatic set_idle_a();
    bus_a.hpos = 10'd700; bus_a.vpos = 10'd10;
    bus_a.hsync_in = 1'b1; bus_a.vsync_in = 1'b1;
  endtask

  task automatic set_idle_b();
    bus_b.hpos = 10'd700; bus_b.vpos = 10'd10;
    bus_b.hsync_in = 1'b1; bus_b.vsync_in = 1'b1;
  endtask

  // Drive one pixel on the chosen DUT and queue its expected output.
  task automatic drive(input bit sel, input int h, input int v,
                       input bit hs, input bit vs,
                       input logic [11:0] rgb, input string nm);
    @(negedge clk);
    if (sel) begin
      set_idle_a();
      bus_b.hpos = 10'(h); bus_b.vpos = 10'(v);
      bus_b.hsync_in = hs; bus_b.vsync_in = vs;
    end else begin
      set_idle_b();
      bus_a.hpos = 10'(h); bus_a.vpos = 10'(v);
      bus_a.hsync_in = hs; bus_a.vsync_in = vs;
    end
    q_due.push_back(cyc + 2);
    q_sel.push_back(sel);
    if (rst_n) q_exp.push_back({hs, vs, rgb});
    else       q_exp.push_back({1'b1, 1'b1, BLK});
    q_nm.push_back(nm);
  endtask

  task automatic tick(input bit sel, input int vres);
    drive(sel, 0, vres, 1'b1, 1'b1, BLK, "tick");
    drive(sel, 1, vres, 1'b1, 1'b1, BLK, "tick_after");
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q_due.size() > 0; i++) @(negedge clk);
    if (q_due.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", q_due.size());
    end
  endtask

  initial begin
    set_idle_a();
    set_idle_b();

    // Reset held mid-line with sync inputs low: outputs stay at reset values.
    for (int i = 0; i < 4; i++) drive(0, 100, 100, 1'b0, 1'b0, BG, "in_reset");
    @(posedge clk);
    #5 rst_n = 1'b1;

    // First pixels after release track inputs two cycles later.
    drive(0, 100, 100, 1'b0, 1'b0, BG,  "post_rst_bg");
    drive(0, 100, 100, 1'b1, 1'b0, BG,  "post_rst_hs");

    // Box edges at the centre position (304..335, 224..255).
    drive(0, 303, 224, 1'b1, 1'b1, BG,  "left_out");
    drive(0, 304, 224, 1'b1, 1'b1, BOX, "left_in");
    drive(0, 335, 224, 1'b1, 1'b1, BOX, "right_in");
    drive(0, 336, 224, 1'b1, 1'b1, BG,  "right_out");
    drive(0, 304, 223, 1'b1, 1'b1, BG,  "top_out");
    drive(0, 304, 255, 1'b0, 1'b1, BOX, "bottom_in");
    drive(0, 304, 256, 1'b1, 1'b0, BG,  "bottom_out");

    // Edge pixels: white with the border feature, background otherwise.
    drive(0, 0,   100, 1'b1, 1'b1, EDGE_EXP, "edge_left");
    drive(0, 639, 479, 1'b1, 1'b1, EDGE_EXP, "edge_corner");

    // Horizontal blanking with the hsync pulse at 656..751.
    drive(0, 640, 10, 1'b1, 1'b1, BLK, "blank");
    for (int h = 650; h <= 760; h++)
      drive(0, h, 10, (h >= 656 && h <= 751) ? 1'b0 : 1'b1, 1'b1, BLK, "hblank");

    // 152 ticks: x walls at 608 and flips; y hit 448 at tick 112, then 40 up to 368.
    for (int t = 0; t < 152; t++) tick(0, 480);
    drive(0, 608, 368, 1'b1, 1'b1, BOX, "t152_tl");
    drive(0, 607, 368, 1'b1, 1'b1, BG,  "t152_left");
    drive(0, 608, 367, 1'b1, 1'b1, BG,  "t152_above");
    drive(0, 638, 399, 1'b1, 1'b1, BOX, "t152_br");
    drive(0, 608, 400, 1'b1, 1'b1, BG,  "t152_below");

    // Tick 153: both axes now moving toward zero -> (606, 366).
    tick(0, 480);
    drive(0, 606, 366, 1'b1, 1'b1, BOX, "t153_tl");
    drive(0, 605, 366, 1'b1, 1'b1, BG,  "t153_left");
    drive(0, 637, 397, 1'b1, 1'b1, BOX, "t153_br");
    drive(0, 638, 366, 1'b1, 1'b1, BG,  "t153_right");
    drive(0, 606, 365, 1'b1, 1'b1, BG,  "t153_above");

    // Small raster: centre (32,32), both axes reach 64 together on tick 16.
    drive(1, 32, 32, 1'b1, 1'b1, BOX, "b_centre");
    drive(1, 31, 32, 1'b1, 1'b1, BG,  "b_centre_left");
    for (int t = 0; t < 16; t++) tick(1, 96);
    drive(1, 64, 64, 1'b1, 1'b1, BOX, "corner_tl");
    drive(1, 63, 64, 1'b1, 1'b1, BG,  "corner_left");
    drive(1, 64, 63, 1'b1, 1'b1, BG,  "corner_above");
    drive(1, 94, 94, 1'b1, 1'b1, BOX, "corner_in");
    tick(1, 96);
    drive(1, 62, 62, 1'b1, 1'b1, BOX, "nw_tl");
    drive(1, 61, 62, 1'b1, 1'b1, BG,  "nw_left");
    drive(1, 62, 61, 1'b1, 1'b1, BG,  "nw_above");
    drive(1, 93, 93, 1'b1, 1'b1, BOX, "nw_br");
    drive(1, 94, 62, 1'b1, 1'b1, BG,  "nw_right");

    // Mid-frame reset: outputs clear at once, position returns to centre.
    drive(0, 606, 366, 1'b0, 1'b1, BOX, "pre_rst");
    repeat (2) @(negedge clk);
    drain();
    #5 rst_n = 1'b0;
    #1 check("async_rst", {bus_a.hsync, bus_a.vsync, bus_a.red, bus_a.green, bus_a.blue},
             {1'b1, 1'b1, BLK});
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    drive(0, 304, 224, 1'b1, 1'b1, BOX, "recentre_in");
    drive(0, 606, 366, 1'b1, 1'b1, BG,  "recentre_old");
    drive(0, 336, 224, 1'b1, 1'b1, BG,  "recentre_out");

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
